// File: rtl/p_to_s_stream_pkg.sv
// Shared types and helpers for the handshaked parallel-to-serial stream converter.
package p_to_s_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } p2s_state_e;

  function automatic int len_width(input int n_slices);
    return $clog2(n_slices + 1);
  endfunction

  // Lengths beyond the word size mean "the whole word".
  function automatic int clamp_len(input int len, input int n_slices);
    return (len > n_slices) ? n_slices : len;
  endfunction

endpackage

// File: rtl/p_to_s_stream_if.sv
// Word-in / slice-out handshake bundle for p_to_s_stream.
// Optional out_rem signal present when P2S_STREAM_REM_EN is defined.
interface p_to_s_stream_if import p_to_s_pkg::*; #(
  parameter int N_SLICES   = 4,
  parameter int SLICE_SIZE = 32
);
  localparam int LEN_W = len_width(N_SLICES);

  logic [N_SLICES*SLICE_SIZE-1:0] in_data;
  logic [LEN_W-1:0]               in_len;
  logic                           in_valid;
  logic                           in_ready;
  logic [SLICE_SIZE-1:0]          out_data;
  logic                           out_valid;
  logic                           out_last;
  logic                           out_ready;
`ifdef P2S_STREAM_REM_EN
  logic [LEN_W-1:0]               out_rem;

  modport slave (
    input  in_data, in_len, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, out_rem
  );
  modport master (
    output in_data, in_len, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_rem
  );
`else
  modport slave (
    input  in_data, in_len, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
  modport master (
    output in_data, in_len, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
`endif

endinterface

// File: rtl/p_to_s_slice_shifter.sv
// ACTIVE word register and remaining-slice counter; the current slice is always
// at a fixed end of the register so the output mux is a plain slice select.
module p_to_s_slice_shifter import p_to_s_pkg::*; #(
  parameter int N_SLICES   = 4,
  parameter int SLICE_SIZE = 32,
  parameter int MSB_FIRST  = 0,
  parameter int LEN_W      = len_width(N_SLICES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_load,
  input  logic                           i_shift,
  input  logic [N_SLICES*SLICE_SIZE-1:0] i_data,
  input  logic [LEN_W-1:0]               i_len,
  output logic [SLICE_SIZE-1:0]          o_data,
  output logic [LEN_W-1:0]               o_rem
);
  localparam int WORD_W = N_SLICES * SLICE_SIZE;

  logic [WORD_W-1:0] r_data;
  logic [LEN_W-1:0]  r_rem;

  // MSB-first words are left-aligned on load so slice len-1 sits in the top slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      if (MSB_FIRST != 0)
        r_data <= i_data << ((N_SLICES - int'(i_len)) * SLICE_SIZE);
      else
        r_data <= i_data;
      r_rem <= i_len;
    end else if (i_shift && (r_rem != '0)) begin
      if (MSB_FIRST != 0)
        r_data <= r_data << SLICE_SIZE;
      else
        r_data <= r_data >> SLICE_SIZE;
      r_rem <= r_rem - LEN_W'(1);
    end
  end

  assign o_data = (MSB_FIRST != 0) ? r_data[WORD_W-1 -: SLICE_SIZE] : r_data[SLICE_SIZE-1:0];
  assign o_rem  = r_rem;

endmodule

// File: rtl/p_to_s_stream.sv
// Handshaked parallel-to-serial converter with a one-word HOLD buffer for bubble-free streaming.
// Define P2S_STREAM_REM_EN to expose the remaining-slice count on out_rem.
module p_to_s_stream import p_to_s_pkg::*; #(
  parameter int N_SLICES   = 4,
  parameter int SLICE_SIZE = 32,
  parameter int MSB_FIRST  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  p_to_s_stream_if.slave  bus
);
  localparam int LEN_W  = len_width(N_SLICES);
  localparam int WORD_W = N_SLICES * SLICE_SIZE;

  localparam logic [1:0] S_EMPTY = EMPTY;
  localparam logic [1:0] S_BUSY  = BUSY;
  localparam logic [1:0] S_FULL  = FULL;

  logic [1:0]            r_state;
  logic [WORD_W-1:0]     r_holdData;
  logic [LEN_W-1:0]      r_holdLen;

  logic [LEN_W-1:0]      w_inLen;
  logic                  w_inXfer;
  logic                  w_inAccept;
  logic                  w_outXfer;
  logic                  w_lastXfer;
  logic                  w_load;
  logic [WORD_W-1:0]     w_loadData;
  logic [LEN_W-1:0]      w_loadLen;
  logic [SLICE_SIZE-1:0] w_sliceData;
  logic [LEN_W-1:0]      w_rem;

  assign w_inLen    = LEN_W'(clamp_len(int'(bus.in_len), N_SLICES));
  assign w_inXfer   = ce & bus.in_valid & bus.in_ready;
  assign w_inAccept = w_inXfer & (w_inLen != '0);
  assign w_outXfer  = ce & bus.out_valid & bus.out_ready;
  assign w_lastXfer = w_outXfer & (w_rem == LEN_W'(1));

  // ACTIVE reloads from HOLD when it drains while full; otherwise the input bypasses HOLD.
  always_comb begin
    w_load     = 1'b0;
    w_loadData = bus.in_data;
    w_loadLen  = w_inLen;
    case (r_state)
      S_EMPTY: w_load = w_inAccept;
      S_BUSY:  w_load = w_inAccept & w_lastXfer;
      S_FULL: begin
        w_load     = w_lastXfer;
        w_loadData = r_holdData;
        w_loadLen  = r_holdLen;
      end
      default: w_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_holdData <= '0;
      r_holdLen  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: if (w_inAccept) r_state <= S_BUSY;
        S_BUSY: begin
          if (w_lastXfer && !w_inAccept) begin
            r_state <= S_EMPTY;
          end else if (w_inAccept && !w_lastXfer) begin
            r_state    <= S_FULL;
            r_holdData <= bus.in_data;
            r_holdLen  <= w_inLen;
          end
        end
        S_FULL:  if (w_lastXfer) r_state <= S_BUSY;
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  p_to_s_slice_shifter #(
    .N_SLICES   (N_SLICES),
    .SLICE_SIZE (SLICE_SIZE),
    .MSB_FIRST  (MSB_FIRST),
    .LEN_W      (LEN_W)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_shift (w_outXfer),
    .i_data  (w_loadData),
    .i_len   (w_loadLen),
    .o_data  (w_sliceData),
    .o_rem   (w_rem)
  );

  assign bus.in_ready  = (r_state != S_FULL);
  assign bus.out_valid = (r_state != S_EMPTY);
  assign bus.out_last  = (w_rem == LEN_W'(1));
  assign bus.out_data  = w_sliceData;
`ifdef P2S_STREAM_REM_EN
  assign bus.out_rem   = w_rem;
`endif

endmodule

// File: tb/tb_p_to_s_stream.sv
// Scoreboard bench for p_to_s_stream: one LSB-first and one MSB-first instance, N_SLICES=4, SLICE_SIZE=8.
module tb_p_to_s_stream;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk   = 1'b0;
  logic clkEn = 1'b1;
  logic rst_n = 1'b0;
  logic ce    = 1'b1;

  int   nVectors     = 0;
  int   nMiscompares = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic       prevStall [2];
  logic [7:0] prevData  [2];

  p_to_s_stream_if #(.N_SLICES(4), .SLICE_SIZE(8)) bus0 ();
  p_to_s_stream_if #(.N_SLICES(4), .SLICE_SIZE(8)) bus1 ();

  p_to_s_stream #(.N_SLICES(4), .SLICE_SIZE(8), .MSB_FIRST(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus0)
  );

  p_to_s_stream #(.N_SLICES(4), .SLICE_SIZE(8), .MSB_FIRST(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus1)
  );

  always #5 if (clkEn) clk = ~clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    nVectors++;
    if (act !== req) begin
      nMiscompares++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Pops one expected slice per output transfer and checks stability while stalled.
  task automatic checkOutput(input int idx, input logic v, input logic r, input logic c,
                             input logic [7:0] d, input logic l);
    exp_t e;
    if (prevStall[idx])
      compare($sformatf("stall_hold%0d", idx), {v, d}, {1'b1, prevData[idx]});
    if (v && r && c) begin
      if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL unexpected_slice%0d actual=%0h required=none", idx, d);
      end else begin
        if (idx == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        compare($sformatf("slice%0d", idx), {l, d}, {e.last, e.data});
      end
    end
    prevStall[idx] = v && !(r && c);
    prevData[idx]  = d;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput(0, bus0.out_valid, bus0.out_ready, ce, bus0.out_data, bus0.out_last);
      checkOutput(1, bus1.out_valid, bus1.out_ready, ce, bus1.out_data, bus1.out_last);
    end
  end

  always @(negedge rst_n) begin
    prevStall[0] = 1'b0;
    prevStall[1] = 1'b0;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected slices in emission order: byte 0 of 'order' leaves first.
  task automatic expectSlices(input int idx, input logic [31:0] order, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = order[i*8 +: 8];
      e.last = (i == n - 1);
      if (idx == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] data, input logic [2:0] len);
    logic acc;
    acc = 1'b0;
    if (idx == 0) begin
      bus0.in_data = data; bus0.in_len = len; bus0.in_valid = 1'b1;
    end else begin
      bus1.in_data = data; bus1.in_len = len; bus1.in_valid = 1'b1;
    end
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = ((idx == 0) ? bus0.in_ready : bus1.in_ready) && ce;
      @(posedge clk);
      #1;
    end
    nVectors++;
    if (!acc) begin
      nMiscompares++;
      $display("[TB] FAIL accept_timeout%0d actual=0 required=1", idx);
    end
    if (idx == 0) bus0.in_valid = 1'b0;
    else          bus1.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++)
      cycles(1);
    compare("drain_q0", q0.size(), 0);
    compare("drain_q1", q1.size(), 0);
    cycles(2);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    prevStall[0] = 1'b0;
    prevStall[1] = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_len = '0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_len = '0; bus1.out_ready = 1'b1;
    cycles(2);
    compare("rst_out_valid", bus0.out_valid, 1'b0);
    compare("rst_in_ready",  bus0.in_ready,  1'b1);
    compare("rst_out_last",  bus0.out_last,  1'b0);
    compare("rst_out_data",  bus0.out_data,  8'h00);
    rst_n = 1'b1;
    cycles(1);

    // Single word, LSB first, one-cycle latency to first slice
    expectSlices(0, 32'h44332211, 4);
    applyStimulus(0, 32'h44332211, 3'd4);
    @(negedge clk);
    compare("latency_valid", bus0.out_valid, 1'b1);
    @(posedge clk);
    #1;
    waitDrain();

    // Back-to-back words stream without a bubble; HOLD full blocks input
    expectSlices(0, 32'h88776655, 4);
    expectSlices(0, 32'h0000BBAA, 2);
    applyStimulus(0, 32'h88776655, 3'd4);
    applyStimulus(0, 32'h0000BBAA, 3'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compare("no_gap_valid", bus0.out_valid, 1'b1);
      if (i == 0) compare("full_in_ready", bus0.in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    waitDrain();

    // Downstream stalls 1,0,0 repeating
    expectSlices(0, 32'h44332211, 4);
    applyStimulus(0, 32'h44332211, 3'd4);
    for (int i = 0; i < 16; i++) begin
      bus0.out_ready = (i % 3 == 0);
      cycles(1);
    end
    bus0.out_ready = 1'b1;
    waitDrain();

    // MSB-first instance, three-slice word
    expectSlices(1, 32'h00AABBCC, 3);
    applyStimulus(1, 32'h00CCBBAA, 3'd3);
    waitDrain();

    // Zero-length word is swallowed
    applyStimulus(0, 32'hDEADBEEF, 3'd0);
    cycles(2);
    compare("len0_out_valid", bus0.out_valid, 1'b0);
    compare("len0_in_ready",  bus0.in_ready,  1'b1);

    // Oversized length clamps to the full word
    expectSlices(0, 32'h0D0C0B0A, 4);
    applyStimulus(0, 32'h0D0C0B0A, 3'd7);
    waitDrain();

    // Clock enable low mid-word freezes everything
    expectSlices(0, 32'h24232221, 4);
    applyStimulus(0, 32'h24232221, 3'd4);
    cycles(1);
    ce = 1'b0;
    cycles(3);
    ce = 1'b1;
    waitDrain();

    // Asynchronous reset with the clock stopped, mid-word
    expectSlices(0, 32'h34333231, 4);
    applyStimulus(0, 32'h34333231, 3'd4);
    cycles(1);
    clkEn = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    compare("amid_out_valid", bus0.out_valid, 1'b0);
    compare("amid_in_ready",  bus0.in_ready,  1'b1);
    compare("amid_out_last",  bus0.out_last,  1'b0);
    compare("amid_out_data",  bus0.out_data,  8'h00);
    q0.delete();
    #1;
    rst_n = 1'b1;
    #1;
    clkEn = 1'b1;
    @(posedge clk);
    #1;
    expectSlices(0, 32'h04030201, 4);
    applyStimulus(0, 32'h04030201, 3'd4);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
